// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder.
// Provides default parameters, the per-stage control bundle that travels
// with each transaction, and the chunk-width / parameter-legality functions.
package pipelined_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    // Control bits that ride alongside a transaction through every stage.
    typedef struct packed {
        logic valid;
        logic sub;
        logic signed_mode;
    } stage_ctrl_t;

    // Bits handled by one slice; guarded so an illegal STAGES=0 cannot divide by zero.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // WIDTH must split evenly into STAGES non-empty slices.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned stages);
        return (stages != 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming bus of the pipelined adder: input handshake with operands and
// mode bits, output handshake with result and flags.
// master: producer/consumer side (drives operands and out_ready).
// slave : adder side (drives in_ready and the result channel).
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = pipelined_adder_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, signed_mode, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, signed_mode, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_slice.sv
// One CHUNK-bit combinational slice of the pipelined adder.
// Ports: a, b, cin in; sum, carry_out (out of MSB) and c_msb (carry into MSB) out.
module adder_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             c_msb
);
    localparam int unsigned CW = CHUNK + 1;

    logic [CHUNK:0] full_c;

    always_comb begin
        full_c    = CW'(a) + CW'(b) + CW'(cin);
        sum       = full_c[CHUNK-1:0];
        carry_out = full_c[CHUNK];
        // MSB sum bit is a^b^carry_in_to_msb, so the carry into the MSB falls out by XOR.
        c_msb     = full_c[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract pipelined over STAGES slices with the carry
// registered between slices. Latency STAGES, throughput one per cycle,
// whole pipeline stalls together when the output is held.
// Ports: clk, rst_n (async active-low), bus (pipelined_adder_if.slave):
//   in_valid/in_ready, a, b, carry_in, sub, signed_mode,
//   out_valid/out_ready, sum, carry_out, overflow.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH=%0d is not a multiple of STAGES=%0d", WIDTH, STAGES);
    end

    // Stage k holds: control, skewed operands (chunks above k still pending),
    // deskewed result chunks 0..k, and the carry out of slice k.
    stage_ctrl_t      ctrl_q [STAGES];
    stage_ctrl_t      ctrl_d [STAGES];
    logic [WIDTH-1:0] opa_q  [STAGES];
    logic [WIDTH-1:0] opa_d  [STAGES];
    logic [WIDTH-1:0] opb_q  [STAGES];
    logic [WIDTH-1:0] opb_d  [STAGES];
    logic [WIDTH-1:0] res_q  [STAGES];
    logic [WIDTH-1:0] res_d  [STAGES];
    logic             cy_q   [STAGES];
    logic             cy_d   [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    logic             adv_c;
    logic [WIDTH-1:0] b_eff_c;
    logic             cin_eff_c;

    logic [CHUNK-1:0] sl_a    [STAGES];
    logic [CHUNK-1:0] sl_b    [STAGES];
    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cin  [STAGES];
    logic             sl_co   [STAGES];
    logic             sl_cmsb [STAGES];

    // Advance enable, operand preprocessing and slice operand selection.
    always_comb begin
        adv_c     = ~ctrl_q[STAGES-1].valid | bus.out_ready;
        b_eff_c   = bus.sub ? ~bus.b : bus.b;
        cin_eff_c = bus.sub | bus.carry_in;
        sl_a[0]   = bus.a[CHUNK-1:0];
        sl_b[0]   = b_eff_c[CHUNK-1:0];
        sl_cin[0] = cin_eff_c;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sl_a[k]   = opa_q[k-1][k*CHUNK +: CHUNK];
            sl_b[k]   = opb_q[k-1][k*CHUNK +: CHUNK];
            sl_cin[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a         (sl_a[k]),
            .b         (sl_b[k]),
            .cin       (sl_cin[k]),
            .sum       (sl_sum[k]),
            .carry_out (sl_co[k]),
            .c_msb     (sl_cmsb[k])
        );
    end

    // Next state: hold everything on stall, otherwise shift one stage.
    always_comb begin
        ctrl_d = ctrl_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        res_d  = res_q;
        cy_d   = cy_q;
        ovf_d  = ovf_q;
        if (adv_c) begin
            ctrl_d[0] = '{valid: bus.in_valid, sub: bus.sub, signed_mode: bus.signed_mode};
            opa_d[0]  = bus.a;
            opb_d[0]  = b_eff_c;
            res_d[0]  = WIDTH'(sl_sum[0]);
            cy_d[0]   = sl_co[0];
            for (int unsigned k = 1; k < STAGES; k++) begin
                ctrl_d[k] = ctrl_q[k-1];
                opa_d[k]  = opa_q[k-1];
                opb_d[k]  = opb_q[k-1];
                res_d[k]  = res_q[k-1];
                res_d[k][k*CHUNK +: CHUNK] = sl_sum[k];
                cy_d[k]   = sl_co[k];
            end
            // ctrl_d of the top stage is the transaction the top slice is finishing now.
            if (ctrl_d[STAGES-1].signed_mode) begin
                ovf_d = sl_co[STAGES-1] ^ sl_cmsb[STAGES-1];
            end else begin
                ovf_d = ctrl_d[STAGES-1].sub ? ~sl_co[STAGES-1] : sl_co[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                res_q[k]  <= '0;
                cy_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            res_q  <= res_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.in_ready  = adv_c;
    assign bus.out_valid = ctrl_q[STAGES-1].valid;
    assign bus.sum       = res_q[STAGES-1];
    assign bus.carry_out = cy_q[STAGES-1];
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations (8/2, 8/1, 32/4).
// Expected results come from an integer-arithmetic reference model; a
// negedge monitor pops and compares, including latency = STAGES + stalls.
module tb_pipelined_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        longint      cyc;
        longint      stl;
    } exp_t;

    logic clk;
    logic rst_n;

    pipelined_adder_if #(.WIDTH(8))  bus8 ();
    pipelined_adder_if #(.WIDTH(8))  bus1 ();
    pipelined_adder_if #(.WIDTH(32)) bus32 ();

    pipelined_adder #(.WIDTH(8),  .STAGES(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    exp_t        sb_q [3][$];
    longint      stall_cnt [3];
    int unsigned stg [3] = '{2, 1, 4};
    longint      cyc;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s %s", name, detail);
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input bit cin, input bit sub, input bit sm);
        exp_t   e;
        longint md   = longint'(1) << w;
        longint half = md / 2;
        longint ua   = longint'(a) & (md - 1);
        longint ub   = longint'(b) & (md - 1);
        longint sa   = (ua >= half) ? ua - md : ua;
        longint sb   = (ub >= half) ? ub - md : ub;
        longint tot;
        longint stot;
        bit     sovf;
        if (sub) begin
            tot    = ua - ub;
            stot   = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            tot    = ua + ub + longint'(cin);
            stot   = sa + sb + longint'(cin);
            e.cout = (tot >= md);
        end
        e.sum = 32'(((tot % md) + md) % md);
        sovf  = (stot < -half) || (stot >= half);
        e.ovf = sm ? sovf : (sub ? !e.cout : e.cout);
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    // grp 0 drives the two 8-bit DUTs together, grp 2 drives the 32-bit DUT.
    task automatic send(input int grp, input logic [31:0] a, input logic [31:0] b,
                        input bit cin, input bit sub, input bit sm, input bit chk_rdy);
        exp_t e;
        bit   ok;
        if (grp == 0) begin
            bus8.in_valid = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0];
            bus8.carry_in = cin; bus8.sub = sub; bus8.signed_mode = sm;
            bus1.in_valid = 1'b1; bus1.a = a[7:0]; bus1.b = b[7:0];
            bus1.carry_in = cin; bus1.sub = sub; bus1.signed_mode = sm;
        end else begin
            bus32.in_valid = 1'b1; bus32.a = a; bus32.b = b;
            bus32.carry_in = cin; bus32.sub = sub; bus32.signed_mode = sm;
        end
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (chk_rdy && t == 0) chk("stream_in_ready", 64'(bus32.in_ready), 64'd1);
            ok = (grp == 0) ? (bus8.in_ready & bus1.in_ready) : bus32.in_ready;
        end
        if (!ok) begin
            fail("send_timeout", "in_ready=0 for 200 cycles, required 1");
        end else if (grp == 0) begin
            e = model(8, a, b, cin, sub, sm);
            e.cyc = cyc;
            e.stl = stall_cnt[0];
            sb_q[0].push_back(e);
            e.stl = stall_cnt[1];
            sb_q[1].push_back(e);
        end else begin
            e = model(32, a, b, cin, sub, sm);
            e.cyc = cyc;
            e.stl = stall_cnt[2];
            sb_q[2].push_back(e);
        end
        @(posedge clk);
        #1;
        bus8.in_valid  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus32.in_valid = 1'b0;
    endtask

    task automatic mon(input int id, input logic ov, input logic rdy, input logic [31:0] s,
                       input logic co, input logic of);
        exp_t e;
        if (ov === 1'b1 && rdy === 1'b1) begin
            if (sb_q[id].size() == 0) begin
                fail($sformatf("unexpected_out[%0d]", id),
                     $sformatf("actual out_valid=1 sum=%0h, required no output", s));
            end else begin
                e = sb_q[id].pop_front();
                chk($sformatf("sum[%0d]", id), 64'(s), 64'(e.sum));
                chk($sformatf("carry_out[%0d]", id), 64'(co), 64'(e.cout));
                chk($sformatf("overflow[%0d]", id), 64'(of), 64'(e.ovf));
                chk($sformatf("latency[%0d]", id), 64'(cyc - e.cyc),
                    64'(longint'(stg[id]) + stall_cnt[id] - e.stl));
            end
        end else if (ov === 1'b1) begin
            stall_cnt[id]++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus8.out_valid,  bus8.out_ready,  32'(bus8.sum),  bus8.carry_out,  bus8.overflow);
            mon(1, bus1.out_valid,  bus1.out_ready,  32'(bus1.sum),  bus1.carry_out,  bus1.overflow);
            mon(2, bus32.out_valid, bus32.out_ready, bus32.sum,      bus32.carry_out, bus32.overflow);
        end
    end

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            #1;
            done = (sb_q[0].size() == 0) && (sb_q[1].size() == 0) && (sb_q[2].size() == 0);
        end
        if (!done) fail("drain_timeout", "results still pending after 100 cycles, required none");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic ov, input logic [31:0] s,
                            input logic co, input logic of, input logic ir);
        chk({tag, "_out_valid"}, 64'(ov), 64'd0);
        chk({tag, "_sum"},       64'(s),  64'd0);
        chk({tag, "_carry_out"}, 64'(co), 64'd0);
        chk({tag, "_overflow"},  64'(of), 64'd0);
        chk({tag, "_in_ready"},  64'(ir), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.carry_in = 1'b0;
        bus8.sub = 1'b0;  bus8.signed_mode = 1'b0;  bus8.out_ready = 1'b1;
        bus1.in_valid = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.carry_in = 1'b0;
        bus1.sub = 1'b0;  bus1.signed_mode = 1'b0;  bus1.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.carry_in = 1'b0;
        bus32.sub = 1'b0; bus32.signed_mode = 1'b0; bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) stall_cnt[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst8",  bus8.out_valid,  32'(bus8.sum), bus8.carry_out,  bus8.overflow,  bus8.in_ready);
        chk_idle("rst1",  bus1.out_valid,  32'(bus1.sum), bus1.carry_out,  bus1.overflow,  bus1.in_ready);
        chk_idle("rst32", bus32.out_valid, bus32.sum,     bus32.carry_out, bus32.overflow, bus32.in_ready);

        // Directed 8-bit cases, then a random 8-bit stream.
        send(0, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 32'h05, 32'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'h05, 32'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        send(0, 32'h80, 32'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        send(0, 32'hFF, 32'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            send(0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        drain();

        // Carry ripples across every slice boundary.
        send(2, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(2, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(2, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Back-to-back stream, in_ready must stay high.
        for (int i = 0; i < 100; i++)
            send(2, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        drain();

        // Backpressure with a full pipeline.
        fork
            begin
                for (int i = 0; i < 24; i++)
                    send(2, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                bus32.out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(bus32.in_ready), 64'd0);
                    chk("bp_out_valid", 64'(bus32.out_valid), 64'd1);
                    if (sb_q[2].size() == 0) fail("bp_queue", "no result pending, required one");
                    else chk("bp_sum_held", 64'(bus32.sum), 64'(sb_q[2][0].sum));
                end
                @(posedge clk);
                #1;
                bus32.out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with transactions in flight.
        for (int i = 0; i < 4; i++)
            send(2, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_out_valid", 64'(bus32.out_valid), 64'd1);
        if (sb_q[2].size() != 0) chk("pre_rst_sum", 64'(bus32.sum), 64'(sb_q[2][0].sum));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("async_rst_sum", 64'(bus32.sum), 64'd0);
        chk("async_rst_carry", 64'(bus32.carry_out), 64'd0);
        for (int i = 0; i < 3; i++) sb_q[i].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        repeat (6) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
